// File: rtl/uart_tx_peripheral_pkg.sv
// Shared definitions for the UART TX peripheral: bus mode encodings, register offsets,
// serialiser states and the baud divider clamp.
package uart_tx_peripheral_pkg;

    localparam logic [1:0] BUS_MODE_NONE  = 2'b00;
    localparam logic [1:0] BUS_MODE_READ  = 2'b01;
    localparam logic [1:0] BUS_MODE_WRITE = 2'b10;

    localparam logic [31:0] UART_DATA   = 32'h0;
    localparam logic [31:0] UART_STATUS = 32'h4;
    localparam logic [31:0] UART_BAUD   = 32'h8;
    localparam logic [31:0] UART_CTRL   = 32'hC;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // A zero divider would stall the bit counter, so it is clamped to one clock per bit.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_peripheral_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; a push to a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: bus register block, TX FIFO, baud counter and
// serialiser FSM, with a level interrupt when the FIFO has drained and the line is idle.
module uart_tx_peripheral
    import uart_tx_peripheral_pkg::*;
#(
    parameter logic [31:0] base_address = 32'h4100,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] DEFAULT_DIV  = 16'd217
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] data_bus_read,
    input  logic [31:0] data_bus_write,
    input  logic        data_bus_select,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          bus_wr, bus_rd;
    logic          hit_data, hit_status, hit_baud, hit_ctrl;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [15:0]   baud_q;
    logic [1:0]    ctrl_q;
    logic          overflow_q;
    logic          tx_irq_q;
    logic          busy;
    logic [31:0]   status_word;
    logic          unused_bits;

    tx_state_e     state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   period_q, period_d;
    logic          bit_end;
    logic          start_frame;

    assign bus_wr     = data_bus_select && (data_bus_mode == BUS_MODE_WRITE);
    assign bus_rd     = data_bus_select && (data_bus_mode == BUS_MODE_READ);
    assign hit_data   = (data_bus_addr == base_address + UART_DATA);
    assign hit_status = (data_bus_addr == base_address + UART_STATUS);
    assign hit_baud   = (data_bus_addr == base_address + UART_BAUD);
    assign hit_ctrl   = (data_bus_addr == base_address + UART_CTRL);
    assign unused_bits = ^data_bus_write[31:16];

    assign fifo_push = bus_wr && hit_data;
    assign busy      = (state_q != TX_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data_bus_write[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q     <= DEFAULT_DIV;
            ctrl_q     <= 2'b01;
            overflow_q <= 1'b0;
            tx_irq_q   <= 1'b0;
        end else begin
            if (bus_wr && hit_baud) baud_q <= clamp_div(data_bus_write[15:0]);
            if (bus_wr && hit_ctrl) ctrl_q <= data_bus_write[1:0];
            // A dropped push wins over a simultaneous clear; they cannot coincide on one bus anyway.
            if (fifo_push && fifo_full && !fifo_pop)
                overflow_q <= 1'b1;
            else if (bus_wr && hit_status && data_bus_write[3])
                overflow_q <= 1'b0;
            tx_irq_q <= ctrl_q[1] && fifo_empty && !busy;
        end
    end

    assign status_word = {24'd0, 4'(fifo_count), overflow_q, fifo_empty, fifo_full, busy};

    always_comb begin
        data_bus_read = 32'd0;
        if (bus_rd) begin
            if (hit_status)    data_bus_read = status_word;
            else if (hit_baud) data_bus_read = {16'd0, baud_q};
            else if (hit_ctrl) data_bus_read = {30'd0, ctrl_q};
        end
    end

    assign bit_end = (div_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        div_d       = div_q;
        period_d    = period_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d        = 1'b1;
                start_frame = ctrl_q[0] && !fifo_empty;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    div_d     = period_q - 16'd1;
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    div_d   = period_q - 16'd1;
                    shift_d = {1'b1, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    start_frame = ctrl_q[0] && !fifo_empty;
                    state_d     = TX_IDLE;
                    tx_d        = 1'b1;
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (start_frame) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            period_d  = baud_q;
            div_d     = baud_q - 16'd1;
            bit_idx_d = 3'd0;
            tx_d      = 1'b0;
            state_d   = TX_START;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            tx_q      <= 1'b1;
            bit_idx_q <= 3'd0;
            div_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            bit_idx_q <= bit_idx_d;
            div_q     <= div_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        period_q <= period_d;
    end

    assign uart_tx = tx_q;
    assign tx_irq  = tx_irq_q;

endmodule
